instr_fetch_unit: RTL and testbench

Parametrised successor to the single-configuration instruction fetch stage. It holds a loadable instruction memory of 2^ADDR_W words and a program counter. Every unstalled cycle it presents a registered instruction, its address and a valid flag to decode. It adds a branch/jump redirect with a bubble, a valid qualifier, and configurable width, depth and reset vector.

---
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/instr_fetch_unit.sv | 90 +++++++++
 tb/tb_instr_fetch_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Decode-side bus of the instruction fetch stage: control and memory-load
// inputs toward the fetch unit, registered instruction/PC/valid back out.
interface instr_fetch_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              stall;
  logic              redirect_en;
  logic [DATA_W-1:0] redirect_pc;
  logic              load_mem_en;
  logic [ADDR_W-1:0] load_mem_addr;
  logic [DATA_W-1:0] load_mem_data;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] pc_out;
  logic              instr_valid;

  modport master (
    output stall, redirect_en, redirect_pc,
    output load_mem_en, load_mem_addr, load_mem_data,
    input  instr, pc_out, instr_valid
  );

  modport slave (
    input  stall, redirect_en, redirect_pc,
    input  load_mem_en, load_mem_addr, load_mem_data,
    output instr, pc_out, instr_valid
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: loadable word memory, program counter and a
// registered instruction/PC/valid output with a one-cycle redirect bubble.
module instr_fetch_unit #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 5,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input logic              clk,
  input logic              rst_n,
  instr_fetch_unit_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] WORD_MASK  = ~DATA_W'(3);
  localparam logic [DATA_W-1:0] RESET_WORD = RESET_PC & WORD_MASK;

  typedef enum logic [1:0] {
    OP_FETCH,
    OP_HOLD,
    OP_BUBBLE,
    OP_LOAD
  } op_e;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [DATA_W-1:0] pc_reg;
  logic [DATA_W-1:0] pc_next;
  logic [DATA_W-1:0] instr_reg;
  logic [DATA_W-1:0] pc_out_reg;
  logic              valid_reg;
  logic [ADDR_W-1:0] fetch_idx;
  op_e               op_next;

  // Higher PC bits are dropped here, so fetch wraps modulo the memory depth.
  assign fetch_idx = pc_reg[ADDR_W+1:2];

  // Priority decode: load > redirect > stall > fetch.
  always_comb begin
    op_next = OP_FETCH;
    pc_next = pc_reg + DATA_W'(4);
    if (bus.load_mem_en) begin
      op_next = OP_LOAD;
      pc_next = pc_reg;
    end else if (bus.redirect_en) begin
      op_next = OP_BUBBLE;
      pc_next = bus.redirect_pc & WORD_MASK;
    end else if (bus.stall) begin
      op_next = OP_HOLD;
      pc_next = pc_reg;
    end
  end

  // Memory has no reset so its contents survive rst_n; loads are ignored in reset.
  always_ff @(posedge clk) begin
    if (rst_n && op_next == OP_LOAD) begin
      mem[bus.load_mem_addr] <= bus.load_mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg     <= RESET_WORD;
      instr_reg  <= '0;
      pc_out_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      pc_reg <= pc_next;
      unique case (op_next)
        OP_FETCH: begin
          instr_reg  <= mem[fetch_idx];
          pc_out_reg <= pc_reg;
          valid_reg  <= 1'b1;
        end
        OP_BUBBLE: begin
          instr_reg <= '0;
          valid_reg <= 1'b0;
        end
        OP_LOAD: begin
          valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.instr       = instr_reg;
  assign bus.pc_out      = pc_out_reg;
  assign bus.instr_valid = valid_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, load, sequential fetch with
// wrap, stall, redirect, priority and mid-run reset with hand-computed outputs.
module tb_instr_fetch_unit;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   check_cnt = 0;
  int   err_cnt   = 0;

  instr_fetch_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  instr_fetch_unit #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .RESET_PC(32'h0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One line per transaction, then compare all three outputs.
  task automatic expect_out(input string tag, input logic [31:0] e_instr,
                            input logic [31:0] e_pc, input logic e_valid);
    $display("[%0t] %s instr=%h pc_out=%h valid=%b", $time, tag,
             bus.instr, bus.pc_out, bus.instr_valid);
    check({tag, ".instr"}, bus.instr, e_instr);
    check({tag, ".pc_out"}, bus.pc_out, e_pc);
    check({tag, ".valid"}, {31'd0, bus.instr_valid}, {31'd0, e_valid});
  endtask

  // Advance one edge and settle past it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall         = 1'b0;
    bus.redirect_en   = 1'b0;
    bus.redirect_pc   = '0;
    bus.load_mem_en   = 1'b0;
    bus.load_mem_addr = '0;
    bus.load_mem_data = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    #1;

    // Preload mem[0] before reset so it must survive reset.
    bus.load_mem_en   = 1'b1;
    bus.load_mem_addr = 5'd0;
    bus.load_mem_data = 32'h2008_0005;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      // Stall/redirect/load are ignored while in reset.
      bus.stall       = (i == 3);
      bus.redirect_en = (i == 5);
      bus.redirect_pc = 32'h0000_0040;
      tick();
    end
    expect_out("reset", 32'h0, 32'h0, 1'b0);

    idle_inputs();
    rst_n = 1'b1;
    tick();
    expect_out("first_fetch", 32'h2008_0005, 32'h0, 1'b1);

    // Load all 32 words; valid must stay low, instr/pc_out held.
    for (int i = 0; i < 32; i++) begin
      bus.load_mem_en   = 1'b1;
      bus.load_mem_addr = 5'(i);
      bus.load_mem_data = 32'hA000_0000 + 32'(i);
      tick();
      if (i == 0 || i == 31)
        expect_out($sformatf("load%0d", i), 32'h2008_0005, 32'h0, 1'b0);
      else
        check($sformatf("load%0d.valid", i), {31'd0, bus.instr_valid}, 32'd0);
    end

    // Reset back to PC 0, then 33 sequential fetches including wrap.
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 33; k++) begin
      tick();
      expect_out($sformatf("seq%0d", k), 32'hA000_0000 + 32'(k % 32), 32'(4 * k), 1'b1);
    end

    // Stall while pc_out=8.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    expect_out("pre_stall", 32'hA000_0002, 32'h8, 1'b1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("stall%0d", i), 32'hA000_0002, 32'h8, 1'b1);
    end
    bus.stall = 1'b0;
    tick();
    expect_out("stall_release", 32'hA000_0003, 32'hC, 1'b1);

    // Redirect to 0x43 -> aligned to 0x40, bubble first.
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h0000_0043;
    tick();
    expect_out("redir_bubble", 32'h0, 32'hC, 1'b0);
    idle_inputs();
    tick();
    expect_out("redir_target", 32'hA000_0010, 32'h40, 1'b1);
    tick();
    expect_out("redir_next", 32'hA000_0011, 32'h44, 1'b1);

    // Redirect wins over stall.
    bus.redirect_en = 1'b1;
    bus.stall       = 1'b1;
    bus.redirect_pc = 32'h0000_0014;
    tick();
    expect_out("redir_stall_bubble", 32'h0, 32'h44, 1'b0);
    idle_inputs();
    tick();
    expect_out("redir_stall_target", 32'hA000_0005, 32'h14, 1'b1);

    // Load wins over redirect: write happens, redirect dropped, pc stays 0x18.
    bus.load_mem_en   = 1'b1;
    bus.load_mem_addr = 5'd6;
    bus.load_mem_data = 32'hDEAD_BEEF;
    bus.redirect_en   = 1'b1;
    bus.redirect_pc   = 32'h0000_0070;
    tick();
    expect_out("load_redir", 32'hA000_0005, 32'h14, 1'b0);
    idle_inputs();
    tick();
    expect_out("load_redir_after", 32'hDEAD_BEEF, 32'h18, 1'b1);

    // High PC bits ignored for indexing but kept in pc_out.
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h1000_0008;
    tick();
    idle_inputs();
    tick();
    expect_out("high_pc", 32'hA000_0002, 32'h1000_0008, 1'b1);

    // Reset mid-run while pc_out=20.
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h0000_0014;
    tick();
    idle_inputs();
    tick();
    expect_out("pre_midreset", 32'hA000_0005, 32'h14, 1'b1);
    rst_n = 1'b0;
    tick();
    expect_out("midreset", 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    tick();
    expect_out("post_reset0", 32'hA000_0000, 32'h0, 1'b1);
    tick();
    expect_out("post_reset1", 32'hA000_0001, 32'h4, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    expect_out("post_reset6", 32'hDEAD_BEEF, 32'h18, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
